// File: rtl/qtz_out_reader.sv
// qtz_out_reader
// Reads the quantizer output register bank back as a stream of segments.
// A single-cycle start walks segment index 0..SEG_COUNT-1. Each segment is
// sliced out of the flattened bank and held in registers behind a
// valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   nrst       asynchronous active-low reset
//   start      single-cycle request to begin a full readout (ignored while busy)
//   bank_data  flattened bank, feature i at [i*ELEM_W +: ELEM_W]
//   out_valid  segment on out_* is valid
//   out_ready  consumer accepts the segment
//   out_data   segment elements, element j at [j*ELEM_W +: ELEM_W]
//   out_mask   bit j set when element j maps to a real feature
//   out_sel    index of the segment currently presented
//   out_last   high while the final segment is presented
//   busy       high in any state other than IDLE
//   done       one-cycle pulse after the final segment is accepted
module qtz_out_reader #(
  parameter int unsigned FEATURE_COUNT = 617,
  parameter int unsigned SEG_LEN       = 62,
  parameter int unsigned ELEM_W        = 8,
  parameter int unsigned SEL_W         = 4
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        start,
  input  logic [FEATURE_COUNT*ELEM_W-1:0] bank_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SEG_LEN*ELEM_W-1:0]   out_data,
  output logic [SEG_LEN-1:0]          out_mask,
  output logic [SEL_W-1:0]            out_sel,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned SEG_COUNT = (FEATURE_COUNT + SEG_LEN - 1) / SEG_LEN;
  localparam int unsigned SEG_BITS  = SEG_LEN * ELEM_W;
  localparam int unsigned PAD_ELEMS = SEG_COUNT * SEG_LEN;
  localparam int unsigned PAD_BITS  = PAD_ELEMS * ELEM_W;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(SEG_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SEL_W-1:0]    seg_cnt;
  logic                load;
  logic [SEL_W-1:0]    load_idx;
  logic [PAD_BITS-1:0] bank_pad;
  logic [PAD_ELEMS-1:0] mask_pad;
  logic [SEG_BITS-1:0] load_data;
  logic [SEG_LEN-1:0]  load_mask;

  // Zero-extending the bank to a whole number of segments turns the partial
  // final segment into an ordinary aligned slice: padding elements read as 0
  // and their mask bits are 0.
  assign bank_pad = PAD_BITS'(bank_data);

  always_comb begin
    mask_pad = '0;
    for (int unsigned i = 0; i < PAD_ELEMS; i++) begin
      mask_pad[i] = (i < FEATURE_COUNT);
    end
  end

  always_comb begin
    load_data = bank_pad[int'(load_idx) * SEG_BITS +: SEG_BITS];
    load_mask = mask_pad[int'(load_idx) * SEG_LEN +: SEG_LEN];
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = SEND;
      SEND: if (out_ready && out_last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    out_valid = (state == SEND);
    busy      = (state != IDLE);
    done      = (state == DONE);
    load      = 1'b0;
    load_idx  = '0;
    if (state == IDLE && start) begin
      load     = 1'b1;
      load_idx = '0;
    end else if (state == SEND && out_ready && !out_last) begin
      load     = 1'b1;
      load_idx = seg_cnt + 1'b1;
    end
  end

  // Segment registers: only change on a load, so they hold under backpressure
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      seg_cnt  <= '0;
      out_data <= '0;
      out_mask <= '0;
      out_last <= 1'b0;
    end else if (load) begin
      seg_cnt  <= load_idx;
      out_data <= load_data;
      out_mask <= load_mask;
      out_last <= (load_idx == LAST_SEL);
    end
  end

  assign out_sel = seg_cnt;

endmodule

// File: tb/tb_qtz_out_reader.sv
module tb_qtz_out_reader;

  localparam int FC = 617;
  localparam int SL = 62;
  localparam int EW = 8;
  localparam int SC = 10;

  logic              clk;
  logic              nrst;
  logic              start;
  logic [FC*EW-1:0]  bank_data;
  logic              out_valid;
  logic              out_ready;
  logic [SL*EW-1:0]  out_data;
  logic [SL-1:0]     out_mask;
  logic [3:0]        out_sel;
  logic              out_last;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  byte unsigned bank_m [FC];

  qtz_out_reader #(
    .FEATURE_COUNT(FC),
    .SEG_LEN(SL),
    .ELEM_W(EW),
    .SEL_W(4)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .start(start),
    .bank_data(bank_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_mask(out_mask),
    .out_sel(out_sel),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference slice model: feature f = s*SL + j, zero beyond the bank
  function automatic logic [SL*EW-1:0] exp_data(input int s);
    logic [SL*EW-1:0] d = '0;
    for (int j = 0; j < SL; j++) begin
      int f = s * SL + j;
      if (f < FC) d[j*EW +: EW] = bank_m[f];
    end
    return d;
  endfunction

  function automatic logic [SL-1:0] exp_mask(input int s);
    logic [SL-1:0] m = '0;
    for (int j = 0; j < SL; j++) m[j] = ((s * SL + j) < FC);
    return m;
  endfunction

  task automatic set_bank(input bit ramp);
    for (int i = 0; i < FC; i++) begin
      bank_m[i] = ramp ? byte'(i % 256) : byte'($urandom_range(0, 255));
      bank_data[i*EW +: EW] = bank_m[i];
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_last"},  out_last, 0);
    chk({tag, "_sel"},   out_sel, 0);
    chk({tag, "_data"},  out_data, 0);
    chk({tag, "_mask"},  out_mask, 0);
  endtask

  // One full readout with a consumer that checks every presented cycle
  task automatic run_readout(input bit rand_ready, input int stall_seg, input int stall_n,
                             input int busy_start_seg, input bit start_in_done,
                             input bit const_checks);
    int exp_idx = 0;
    int hs = 0;
    int stalls = 0;
    int cyc = 0;
    bit seen_done = 0;
    bit busy_pulsed = 0;
    bit rdy;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen_done && cyc < 300) begin
      start = 1'b0;
      if (done) begin
        seen_done = 1;
      end else begin
        chk("valid", out_valid, 1);
        chk("busy",  busy, 1);
        chk("sel",   out_sel, exp_idx);
        chk("data",  out_data, exp_data(exp_idx));
        chk("mask",  out_mask, exp_mask(exp_idx));
        chk("last",  out_last, (exp_idx == SC - 1));
        if (const_checks) begin
          if (exp_idx == 3) chk("seg3_e0", out_data[7:0], 186);
          if (exp_idx == 8) chk("seg8_e61", out_data[61*EW +: EW], 45);
          if (exp_idx == 9) begin
            chk("seg9_ones", $countones(out_mask), 59);
            chk("seg9_tail", out_data[59*EW +: 3*EW], 0);
          end
        end
        rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (exp_idx == stall_seg && stalls < stall_n) begin
          rdy = 1'b0;
          stalls++;
        end
        if (exp_idx == busy_start_seg && !busy_pulsed) begin
          start = 1'b1;
          busy_pulsed = 1;
        end
        out_ready = rdy;
        if (rdy) begin
          hs++;
          exp_idx++;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("done_seen",  seen_done, 1);
    chk("done_at_hs", hs, SC);
    chk("done_valid", out_valid, 0);
    chk("done_busy",  busy, 1);
    start = start_in_done;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    nrst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    bank_data = '0;
    set_bank(1'b1);

    // Asynchronous reset asserted mid-cycle
    @(posedge clk); #2;
    nrst = 1'b0;
    #1;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_reset");

    // Full stream, ramp bank, ready held high
    run_readout(1'b0, -1, 0, -1, 1'b0, 1'b1);

    // Backpressure on segment 2
    set_bank(1'b0);
    run_readout(1'b0, 2, 3, -1, 1'b0, 1'b0);

    // Start pulsed during segment 4 and in the DONE cycle
    set_bank(1'b0);
    run_readout(1'b0, -1, 0, 4, 1'b1, 1'b0);

    // Reset in the middle of a readout
    set_bank(1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && out_sel != 4'd6; c++) begin
      @(posedge clk); #1;
    end
    chk("mid_sel6", out_sel, 6);
    #2;
    nrst = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("mid_no_done", done, 0);
      chk("mid_no_busy", busy, 0);
    end
    run_readout(1'b0, -1, 0, -1, 1'b0, 1'b0);

    // Random ready, three back-to-back readouts with fresh bank contents
    for (int r = 0; r < 3; r++) begin
      set_bank(1'b0);
      run_readout(1'b1, -1, 0, -1, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
